// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//   Registered SEL_W-to-2**SEL_W one-hot decoder with enable, used as the
//   digit/row select driver for multiplexed displays and keypad scanning.
//   Two modes: direct (host-supplied select) and scan (auto-advancing index
//   with a programmable dwell per index). All outputs are registered.
//
//   Build option: define SCAN_DECODER_ACTIVE_LOW_EN to make onehot one-cold
//   (reset/off value all-ones, active bit low) for common-anode digit drive.
//   idx and wrap are unaffected by the option.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      block enable; low forces onehot inactive
//   mode       in   1      0 = direct, 1 = scan
//   sel_valid  in   1      direct-mode select strobe
//   sel        in   SEL_W  direct-mode select value
//   onehot     out  OUT_W  registered decode of idx
//   idx        out  SEL_W  current registered index
//   wrap       out  1      one-cycle pulse when scan wraps to 0
//
// State table
//   ST_OFF    | disabled, onehot inactive, idx retained, dwell cleared
//   ST_DIRECT | idx loaded from sel on each sel_valid strobe
//   ST_SCAN   | idx advances every DWELL cycles, wraps after SCAN_LAST
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int SEL_W     = 3,
    parameter int DWELL     = 4,
    parameter int SCAN_LAST = 2**SEL_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   onehot,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [15:0]      CNT_LAST = 16'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(SCAN_LAST);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OFF_VAL = '1;
`else
    localparam logic [OUT_W-1:0] OFF_VAL = '0;
`endif

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nx;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nx;
    logic               r_wrap;
    logic               w_wrap_nx;
    logic [OUT_W-1:0]   r_onehot;
    logic [OUT_W-1:0]   w_dec;
    logic [OUT_W-1:0]   w_onehot_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
            r_onehot <= OFF_VAL;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_cnt    <= w_cnt_nx;
            r_wrap   <= w_wrap_nx;
            r_onehot <= w_onehot_nx;
        end
    end

    always_comb begin
        w_state_nx  = ST_OFF;
        w_idx_nx    = r_idx;
        w_cnt_nx    = '0;
        w_wrap_nx   = 1'b0;
        w_dec       = '0;

        if (en) begin
            w_state_nx = mode ? ST_SCAN : ST_DIRECT;
        end

        case (w_state_nx)
            ST_DIRECT: begin
                if (sel_valid) begin
                    w_idx_nx = sel;
                end
            end
            ST_SCAN: begin
                // The entry edge only loads the state with a zero count, so
                // the starting index is shown for a full DWELL cycles.
                if (r_state == ST_SCAN) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nx = '0;
                        // >= so an out-of-range index from direct mode
                        // also wraps instead of walking up to OUT_W-1.
                        if (r_idx >= IDX_LAST) begin
                            w_idx_nx  = '0;
                            w_wrap_nx = 1'b1;
                        end else begin
                            w_idx_nx = r_idx + SEL_W'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
            end
            default: ;
        endcase

        // Decode from the next-state index so onehot and idx move together.
        if (w_state_nx != ST_OFF) begin
            w_dec[w_idx_nx] = 1'b1;
        end
        w_onehot_nx = w_dec ^ OFF_VAL;
    end

    assign onehot = r_onehot;
    assign idx    = r_idx;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel = 3'd0;

    logic [7:0] oh0, oh1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    // Main instance: DWELL=4, SCAN_LAST=5. Second instance: DWELL=1, full range.
    scan_decoder #(.SEL_W(3), .DWELL(4), .SCAN_LAST(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel_valid(sel_valid), .sel(sel),
        .onehot(oh0), .idx(idx0), .wrap(wrap0)
    );

    scan_decoder #(.SEL_W(3), .DWELL(1), .SCAN_LAST(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel_valid(sel_valid), .sel(sel),
        .onehot(oh1), .idx(idx1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pol(input logic [7:0] v);
        return INV ? ~v : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per instance, the shown index, how many cycles it
    // has been shown during the current scan, and whether output is active.
    int dw  [2] = '{4, 1};
    int lst [2] = '{5, 7};
    int m_idx  [2] = '{0, 0};
    int m_held [2] = '{0, 0};
    bit m_on   [2] = '{0, 0};
    bit m_scan [2] = '{0, 0};
    bit m_wrap [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_idx[i] = 0; m_held[i] = 0; m_on[i] = 0; m_scan[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_wrap[i] = 0;
                if (!en) begin
                    m_on[i] = 0;
                    m_scan[i] = 0;
                end else if (!mode) begin
                    m_on[i] = 1;
                    m_scan[i] = 0;
                    if (sel_valid) m_idx[i] = int'(sel);
                end else begin
                    m_on[i] = 1;
                    if (!m_scan[i]) begin
                        m_scan[i] = 1;
                        m_held[i] = 1;
                    end else if (m_held[i] == dw[i]) begin
                        m_held[i] = 1;
                        if (m_idx[i] >= lst[i]) begin
                            m_idx[i] = 0;
                            m_wrap[i] = 1;
                        end else begin
                            m_idx[i] = m_idx[i] + 1;
                        end
                    end else begin
                        m_held[i] = m_held[i] + 1;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] m_onehot(input int i);
        logic [7:0] v;
        v = m_on[i] ? (8'd1 << m_idx[i]) : 8'd0;
        return pol(v);
    endfunction

    always @(negedge clk) begin
        check("model_oh0",   32'(oh0),   32'(m_onehot(0)));
        check("model_idx0",  32'(idx0),  32'(m_idx[0]));
        check("model_wrap0", 32'(wrap0), 32'(m_wrap[0]));
        check("model_oh1",   32'(oh1),   32'(m_onehot(1)));
        check("model_idx1",  32'(idx1),  32'(m_idx[1]));
        check("model_wrap1", 32'(wrap1), 32'(m_wrap[1]));
    end

    task automatic wait_idx0(input logic [2:0] target);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (idx0 == target) found = 1;
        end
        check("wait_idx0_timeout", 32'(found), 32'd1);
    endtask

    logic [7:0] dir_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        int wraps;
        int maxidx;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oh0",   32'(oh0),   32'(pol(8'h00)));
        check("reset_idx0",  32'(idx0),  32'd0);
        check("reset_wrap0", 32'(wrap0), 32'd0);
        check("reset_oh1",   32'(oh1),   32'(pol(8'h00)));

        // Scan from idx 0.
        en = 1'b1; mode = 1'b1; rst_n = 1'b1;
        wraps = 0; maxidx = 0;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            check("scan_seq_idx0", 32'(idx0), 32'(((n - 1) / 4) % 6));
            if (n <= 9) begin
                check("scan1_idx", 32'(idx1), 32'((n - 1) % 8));
                check("scan1_oh",  32'(oh1),  32'(pol(dir_tab[(n - 1) % 8])));
            end
            if (n == 25) check("scan_wrap_at_5to0", 32'(wrap0), 32'd1);
            if (wrap0) wraps++;
            if (int'(idx0) > maxidx) maxidx = int'(idx0);
        end
        check("scan_wrap_count", 32'(wraps), 32'd1);
        check("scan_max_idx", 32'(maxidx), 32'd5);

        // Asynchronous reset between edges while scanning at idx 3.
        wait_idx0(3'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_idx0",  32'(idx0),  32'd0);
        check("async_oh0",   32'(oh0),   32'(pol(8'h00)));
        check("async_wrap0", 32'(wrap0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decode sweep.
        mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sel_valid = 1'b1; sel = 3'(k);
            @(negedge clk);
            check("direct_oh0",  32'(oh0),  32'(pol(dir_tab[k])));
            check("direct_idx0", 32'(idx0), 32'(k));
        end
        sel_valid = 1'b0; sel = 3'd3;
        repeat (3) begin
            @(negedge clk);
            check("direct_hold", 32'(oh0), 32'(pol(8'h80)));
        end

        // Out-of-range index carried into scan.
        sel_valid = 1'b1; sel = 3'd7;
        @(negedge clk);
        sel_valid = 1'b0; mode = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("oor_hold7", 32'(idx0), 32'd7);
        end
        @(negedge clk);
        check("oor_idx0",  32'(idx0),  32'd0);
        check("oor_wrap0", 32'(wrap0), 32'd1);

        // Enable gating mid-scan at idx 2.
        wait_idx0(3'd2);
        en = 1'b0;
        @(negedge clk);
        check("gate_off_oh0",  32'(oh0),  32'(pol(8'h00)));
        check("gate_off_idx0", 32'(idx0), 32'd2);
        repeat (9) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("gate_on_oh0", 32'(oh0), 32'(pol(8'h04)));
        repeat (3) begin
            @(negedge clk);
            check("gate_dwell_hold", 32'(idx0), 32'd2);
        end
        @(negedge clk);
        check("gate_dwell_adv", 32'(idx0), 32'd3);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel_valid = ($urandom_range(0, 3) == 0);
            sel = 3'($urandom_range(0, 7));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
